// File: rtl/seq_pattern_gen_pkg.sv
// seq_pattern_gen_pkg: shared state encoding and default widths for the serial pattern transmitter.
package seq_pattern_gen_pkg;
    localparam int DEF_PAT_W = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_REP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/seq_pattern_gen_piso.sv
// seq_pattern_gen_piso: parallel-load shift register with a down-counting bit index and registered serial bit.
module seq_pattern_gen_piso
    import seq_pattern_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_clr,
    input  logic [PAT_W-1:0] i_data,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_bit,
    output logic             o_last
);
    logic [PAT_W-1:0] r_shreg;
    logic [LEN_W-1:0] r_idx;
    logic             r_bit;
    logic [PAT_W-1:0] w_aligned;

    // Left-align the frame so the outgoing bit always sits at the MSB.
    assign w_aligned = i_data << (LEN_W'(PAT_W) - i_len);
    assign o_bit     = r_bit;
    assign o_last    = (r_idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_idx   <= '0;
            r_bit   <= 1'b0;
        end else if (i_clr) begin
            r_shreg <= '0;
            r_idx   <= '0;
            r_bit   <= 1'b0;
        end else if (i_load) begin
            r_shreg <= w_aligned;
            r_idx   <= i_len - 1'b1;
            r_bit   <= w_aligned[PAT_W-1];
        end else if (i_shift) begin
            r_shreg <= r_shreg << 1;
            r_idx   <= r_idx - 1'b1;
            r_bit   <= r_shreg[PAT_W-2];
        end
    end
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first test-pattern transmitter with programmable frame length and repeat count.
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    input  logic [REP_W-1:0] i_rep,
    output logic             o_seq,
    output logic             o_seq_valid,
    output logic             o_busy,
    output logic             o_done
);
    state_t           r_state, w_state_nx;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [REP_W-1:0] r_rep_left, w_rep_nx;
    logic [LEN_W-1:0] w_len_in;
    logic             w_load, w_shift, w_clr, w_use_in, w_capture;
    logic             w_valid_nx, w_busy_nx, w_done_nx, w_last;

    assign w_len_in = (i_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : i_len;

    seq_pattern_gen_piso #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_piso (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_shift(w_shift),
        .i_clr  (w_clr),
        .i_data (w_use_in ? i_pattern : r_pat),
        .i_len  (w_use_in ? w_len_in : r_len),
        .o_bit  (o_seq),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_clr      = 1'b0;
        w_use_in   = 1'b0;
        w_capture  = 1'b0;
        w_valid_nx = 1'b0;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_rep_nx   = r_rep_left;
        case (r_state)
            S_IDLE: begin
                if (i_abort) begin
                    w_clr = 1'b1;
                end else if (i_start) begin
                    w_capture = 1'b1;
                    if (w_len_in == '0 || i_rep == '0) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                        w_clr      = 1'b1;
                    end else begin
                        w_state_nx = S_SHIFT;
                        w_load     = 1'b1;
                        w_use_in   = 1'b1;
                        w_valid_nx = 1'b1;
                        w_busy_nx  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (i_abort) begin
                    w_state_nx = S_IDLE;
                    w_clr      = 1'b1;
                end else if (w_last && r_rep_left > REP_W'(1)) begin
                    w_rep_nx   = r_rep_left - 1'b1;
                    w_load     = 1'b1;
                    w_valid_nx = 1'b1;
                    w_busy_nx  = 1'b1;
                end else if (w_last) begin
                    w_state_nx = S_DONE;
                    w_done_nx  = 1'b1;
                    w_clr      = 1'b1;
                end else begin
                    w_shift    = 1'b1;
                    w_valid_nx = 1'b1;
                    w_busy_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_clr      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_len       <= '0;
            r_rep_left  <= '0;
            o_seq_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pat       <= w_capture ? i_pattern : r_pat;
            r_len       <= w_capture ? w_len_in : r_len;
            r_rep_left  <= w_capture ? i_rep : w_rep_nx;
            o_seq_valid <= w_valid_nx;
            o_busy      <= w_busy_nx;
            o_done      <= w_done_nx;
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: randomized self-checking bench against a bit-stream reference model.
module tb_seq_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_pattern = '0;
    logic [3:0] i_len = '0;
    logic [3:0] i_rep = '0;
    logic       o_seq, o_seq_valid, o_busy, o_done;
    logic [3:0] obs, exp_v;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         exp_q[$];

    always #5 clk = ~clk;

    assign obs = {o_seq, o_seq_valid, o_busy, o_done};

    seq_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_pattern  (i_pattern),
        .i_len      (i_len),
        .i_rep      (i_rep),
        .o_seq      (o_seq),
        .o_seq_valid(o_seq_valid),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Expected serial stream: rep copies of pattern[len_eff-1:0], MSB first.
    function automatic void model(input logic [7:0] p, input int l, input int r);
        int le;
        exp_q.delete();
        le = (l > 8) ? 8 : l;
        for (int f = 0; f < r; f++)
            for (int i = le - 1; i >= 0; i--)
                exp_q.push_back(p[i]);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if (obs !== 4'b0000) $display("FAIL reset_hold got %b exp 0000", obs);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (obs !== 4'b0000) $display("FAIL reset_release got %b exp 0000", obs);
        else n_pass++;
    endtask

    // Runs one start request; with disturb, inputs and start are scrambled while busy.
    task automatic test_frame(input string name, input logic [7:0] p, input logic [3:0] l,
                              input logic [3:0] r, input bit disturb);
        int n;
        model(p, l, r);
        n = exp_q.size();
        @(negedge clk);
        i_pattern = p;
        i_len     = l;
        i_rep     = r;
        i_start   = 1'b1;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            i_start = (disturb && k <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (disturb) begin
                i_pattern = 8'($urandom);
                i_len     = 4'($urandom);
                i_rep     = 4'($urandom);
            end
            exp_v = (k <= n) ? {exp_q[k-1], 3'b110} : (k == n + 1) ? 4'b0001 : 4'b0000;
            n_chk++;
            if (obs !== exp_v) $display("FAIL %s cyc%0d got %b exp %b", name, k, obs, exp_v);
            else n_pass++;
        end
        i_start = 1'b0;
    endtask

    task automatic test_abort();
        model(8'h0D, 4, 1);
        @(negedge clk);
        i_pattern = 8'h0D;
        i_len     = 4'd4;
        i_rep     = 4'd1;
        i_start   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            exp_v = (k <= 3) ? {exp_q[k-1], 3'b110} : 4'b0000;
            n_chk++;
            if (obs !== exp_v) $display("FAIL abort cyc%0d got %b exp %b", k, obs, exp_v);
            else n_pass++;
            i_abort = (k == 3);
        end
        i_start = 1'b1;
        i_abort = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_abort = 1'b0;
            n_chk++;
            if (obs !== 4'b0000) $display("FAIL abort_start_idle cyc%0d got %b exp 0000", k, obs);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        model(8'hA5, 8, 2);
        @(negedge clk);
        i_pattern = 8'hA5;
        i_len     = 4'd8;
        i_rep     = 4'd2;
        i_start   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            exp_v = {exp_q[k-1], 3'b110};
            n_chk++;
            if (obs !== exp_v) $display("FAIL rst_mid_pre cyc%0d got %b exp %b", k, obs, exp_v);
            else n_pass++;
        end
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (obs !== 4'b0000) $display("FAIL rst_mid_async got %b exp 0000", obs);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== 4'b0000) $display("FAIL rst_mid_after cyc%0d got %b exp 0000", k, obs);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++)
            test_frame("random", 8'($urandom), 4'($urandom), 4'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_frame("basic_0D", 8'h0D, 4'd4, 4'd1, 1'b0);
        test_frame("repeat_05", 8'h05, 4'd3, 4'd3, 1'b0);
        test_frame("len_zero", 8'hFF, 4'd0, 4'd3, 1'b0);
        test_frame("rep_zero", 8'hFF, 4'd5, 4'd0, 1'b0);
        test_frame("clamp_A5", 8'hA5, 4'd12, 4'd1, 1'b0);
        test_abort();
        test_frame("after_abort", 8'h0D, 4'd4, 4'd1, 1'b0);
        test_rst_mid();
        test_frame("after_rst", 8'h3C, 4'd6, 4'd2, 1'b0);
        test_frame("back_to_back", 8'h96, 4'd8, 4'd3, 1'b1);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
